demux64_1_4_buf: RTL
====================

DEMUX64_1_4_BUF -- requirements
Module: demux64_1_4_buf

Interface
REQ-001 SHALL have parameter WIDTH, default 64: data width of the input and of every output.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, synchronous, active-low.
REQ-004 SHALL have port in_data, input, WIDTH bits: word offered for routing.
REQ-005 SHALL have port in_sel, input, 2 bits: destination output index 0..3 for in_data.
REQ-006 SHALL have port in_valid, input, 1 bit: in_data/in_sel valid this cycle.
REQ-007 SHALL have port in_ready, output, 1 bit: block accepts the offered word this cycle.
REQ-008 SHALL have ports z0, z1, z2, z3, output, WIDTH bits each: head word of output k.
REQ-009 SHALL have port out_valid, output, 4 bits: bit k = zk holds a valid word.
REQ-010 SHALL have port out_ready, input, 4 bits: bit k = consumer k takes zk this cycle.

Function
REQ-011 SHALL contain one independent 2-entry FIFO slot per output k (k = 0..3).
REQ-012 SHALL assert in_ready = 1 exactly when slot[in_sel] holds fewer than 2 words; in_ready is combinational from in_sel and slot occupancy only, never from in_valid or out_ready.
REQ-013 SHALL treat a push as in_valid & in_ready at a rising edge; the word is written only into slot[in_sel], and other slots are unaffected.
REQ-014 SHALL treat a pop on output k as out_valid[k] & out_ready[k] at a rising edge.
REQ-015 SHALL show a word pushed at edge N as zk with out_valid[k]=1 from cycle N+1 (latency 1 cycle); it SHALL NOT pass combinationally to the output.
REQ-016 SHALL run the per-slot state machine EMPTY, ONE, TWO: EMPTY+push->ONE; ONE+push only->TWO; ONE+pop only->EMPTY; ONE+push+pop->ONE; TWO+pop->ONE; all other combinations hold state.
REQ-017 SHALL block a push when a slot is TWO, even if a pop occurs on the same edge.
REQ-018 SHALL preserve FIFO order per slot: on ONE+push+pop, the new word becomes the head at the next cycle.
REQ-019 SHALL drive out_valid[k]=0 and zk=0 whenever slot k is EMPTY.
REQ-020 SHALL leave a stalled slot (out_ready[k]=0) unaffected by traffic to any other slot.
REQ-021 SHALL accept a change of in_sel while in_valid=1 and in_ready=0; no ordering guarantee is given across different outputs.

Reset
REQ-022 SHALL, on a rising edge with rst_n=0, set every slot to EMPTY, out_valid=4'b0000 and z0..z3=0.
REQ-023 SHALL give in_ready=1 in the cycle after reset, because all slots are EMPTY.
REQ-024 SHALL, on reset mid-operation, discard all buffered words; no push or pop takes effect on the reset edge.

Structure
REQ-025 SHALL take from shared package demux_pkg: constant NOUT=4, constant SEL_W=2, and the slot-state enum (EMPTY, ONE, TWO).
REQ-026 SHALL implement the buffer as sub-module demux_slot (one 2-entry FIFO with push, pop, head, valid and full), instantiated 4 times.
REQ-027 SHALL contain no logic beyond sel decode, in_ready mux and slot instances at top level.

Verification
REQ-028 SHALL cover basic routing: after reset, push 64'd0..64'd3 with in_sel 0..3 on 4 consecutive edges, out_ready=4'b1111 -> zk=k and out_valid[k]=1 exactly one cycle after each push.
REQ-029 SHALL cover full slot: out_ready=0, push 64'hA then 64'hB to sel 2 -> in_ready=0 for sel 2 and 1 for sel 0; a third push of 64'hC to sel 2 is not accepted; popping then yields A, B in order.
REQ-030 SHALL cover a full slot with a simultaneous pop: slot 1 holds A, B; assert out_ready[1] with in_valid=1 and in_sel=1 -> only the pop occurs, the slot is left with B, and in_ready rises the next cycle.
REQ-031 SHALL cover ONE push+pop: slot 3 holds 64'h5; push 64'h6 with out_ready[3]=1 -> next cycle z3=64'h6, out_valid[3]=1, state ONE.
REQ-032 SHALL cover reset mid-operation: with all slots TWO, rst_n=0 for one edge -> out_valid=0, z0..z3=0, in_ready=1; pushes issued during the reset edge are dropped.

Source files
------------

// File: rtl/demux_pkg.sv
// Shared constants and slot-state encoding for the 1-to-4 buffered demux.
package demux_pkg;
  localparam int NOUT  = 4;
  localparam int SEL_W = 2;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } slot_state_e;
endpackage

// File: rtl/demux_slot.sv
// Two-entry FIFO slot: registered head, no combinational input-to-output path.
module demux_slot
  import demux_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             valid,
  output logic             full
);
  slot_state_e      state_q, state_d;
  logic [WIDTH-1:0] mem0_q, mem1_q;
  logic             do_push, do_pop;

  // A full slot refuses the push even when it pops on the same edge.
  assign do_push = push & (state_q != TWO);
  assign do_pop  = pop & (state_q != EMPTY);

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= EMPTY;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      EMPTY: if (do_push) state_d = ONE;
      ONE: begin
        if (do_push && !do_pop)      state_d = TWO;
        else if (do_pop && !do_push) state_d = EMPTY;
      end
      TWO:     if (do_pop) state_d = ONE;
      default: state_d = EMPTY;
    endcase
  end

  // Vacated entries are cleared so an empty slot presents zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem0_q <= '0;
      mem1_q <= '0;
    end else begin
      unique case (state_q)
        EMPTY: if (do_push) mem0_q <= din;
        ONE: begin
          if (do_push)     mem0_q <= do_pop ? din : mem0_q;
          else if (do_pop) mem0_q <= '0;
          if (do_push && !do_pop) mem1_q <= din;
        end
        TWO: if (do_pop) begin
          mem0_q <= mem1_q;
          mem1_q <= '0;
        end
        default: begin
          mem0_q <= '0;
          mem1_q <= '0;
        end
      endcase
    end
  end

  assign head  = mem0_q;
  assign valid = (state_q != EMPTY);
  assign full  = (state_q == TWO);
endmodule

// File: rtl/demux64_1_4_buf.sv
// 1-to-4 demux with an independent 2-entry buffer per output.
module demux64_1_4_buf
  import demux_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] z0,
  output logic [WIDTH-1:0] z1,
  output logic [WIDTH-1:0] z2,
  output logic [WIDTH-1:0] z3,
  output logic [3:0]       out_valid,
  input  logic [3:0]       out_ready
);
  logic [NOUT-1:0]            full_vec;
  logic [NOUT-1:0]            push_vec;
  logic [NOUT-1:0][WIDTH-1:0] z_arr;

  // Ready depends only on the selected slot's occupancy.
  assign in_ready = ~full_vec[in_sel];

  for (genvar k = 0; k < NOUT; k++) begin : g_slot
    assign push_vec[k] = in_valid & in_ready & (in_sel == SEL_W'(k));

    demux_slot #(.WIDTH(WIDTH)) u_slot (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push_vec[k]),
      .din   (in_data),
      .pop   (out_ready[k]),
      .head  (z_arr[k]),
      .valid (out_valid[k]),
      .full  (full_vec[k])
    );
  end

  assign z0 = z_arr[0];
  assign z1 = z_arr[1];
  assign z2 = z_arr[2];
  assign z3 = z_arr[3];
endmodule
